// File: rtl/fft_indexer_r2_cfg.sv
// Radix-2 DIF FFT operand/twiddle address generator with runtime size selection.
// Emits A/B operand indices per butterfly, stage by stage, with a stall handshake.
module fft_indexer_r2_cfg #(
    parameter int BW_FFTP  = 4,
    parameter int BW_STAGE = 3
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Start,
    input  logic [BW_STAGE-1:0] Log2N,
    input  logic                Stall,
    output logic [BW_FFTP-1:0]  Index,
    output logic                IsB,
    output logic [BW_STAGE-1:0] Stage,
    output logic [BW_FFTP-2:0]  Twiddle,
    output logic                Valid,
    output logic                Busy,
    output logic                End,
    output logic                CfgErr
);

    localparam int BFLY_W = BW_FFTP - 1;
    localparam logic [BW_STAGE-1:0] FFTP_S = BW_STAGE'(BW_FFTP);
    localparam logic [BFLY_W-1:0]   BFLY_ONES = {BFLY_W{1'b1}};

    logic                busy_q;
    logic                isb_q;
    logic                end_q;
    logic                cfg_err_q;
    logic [BW_STAGE-1:0] len_q;
    logic [BW_STAGE-1:0] stage_q;
    logic [BFLY_W-1:0]   bfly_q;

    logic [BW_STAGE-1:0] pos;
    logic [BW_STAGE-1:0] tw_shift;
    logic [BFLY_W-1:0]   low_mask;
    logic [BFLY_W-1:0]   last_bfly;
    logic                last_stage;
    logic [BW_FFTP-1:0]  a_idx;
    logic [BW_FFTP-1:0]  b_idx;
    logic [BFLY_W-1:0]   twiddle_raw;
    logic                consume;
    logic                start_ok;
    logic                cfg_bad;

    always_comb begin
        // pos is the bit where the zero is inserted; it also sets the span h = 2^pos
        pos         = len_q - stage_q - BW_STAGE'(1);
        tw_shift    = stage_q + FFTP_S - len_q;
        low_mask    = ~(BFLY_ONES << pos);
        last_bfly   = BFLY_ONES >> (FFTP_S - len_q);
        last_stage  = (stage_q == len_q - BW_STAGE'(1));
        a_idx       = {bfly_q & ~low_mask, 1'b0} | {1'b0, bfly_q & low_mask};
        b_idx       = a_idx | (BW_FFTP'(1) << pos);
        twiddle_raw = (bfly_q & low_mask) << tw_shift;
        consume     = busy_q & ~Stall;
        start_ok    = Start & ~busy_q & ~end_q;
        cfg_bad     = (Log2N == '0) || (Log2N > FFTP_S);
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            busy_q    <= 1'b0;
            isb_q     <= 1'b0;
            end_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            len_q     <= '0;
            stage_q   <= '0;
            bfly_q    <= '0;
        end else begin
            end_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            if (start_ok) begin
                if (cfg_bad) begin
                    cfg_err_q <= 1'b1;
                end else begin
                    busy_q  <= 1'b1;
                    len_q   <= Log2N;
                    stage_q <= '0;
                    bfly_q  <= '0;
                    isb_q   <= 1'b0;
                end
            end else if (consume) begin
                if (!isb_q) begin
                    isb_q <= 1'b1;
                end else begin
                    isb_q <= 1'b0;
                    if (bfly_q == last_bfly) begin
                        bfly_q <= '0;
                        if (last_stage) begin
                            busy_q  <= 1'b0;
                            end_q   <= 1'b1;
                            stage_q <= '0;
                        end else begin
                            stage_q <= stage_q + BW_STAGE'(1);
                        end
                    end else begin
                        bfly_q <= bfly_q + BFLY_W'(1);
                    end
                end
            end
        end
    end

    // Outputs are forced to zero whenever no item is being presented
    assign Index   = busy_q ? (isb_q ? b_idx : a_idx) : '0;
    assign IsB     = busy_q & isb_q;
    assign Stage   = busy_q ? stage_q : '0;
    assign Twiddle = busy_q ? twiddle_raw : '0;
    assign Valid   = busy_q;
    assign Busy    = busy_q;
    assign End     = end_q;
    assign CfgErr  = cfg_err_q;

endmodule

// File: tb/tb_fft_indexer_r2_cfg.sv
// Bench for fft_indexer_r2_cfg: directed scenarios plus randomized stall/Start
// traffic compared against an arithmetic model of the butterfly address sequence.
module tb_fft_indexer_r2_cfg;

    logic       Clock;
    logic       Reset_n;
    logic       Start;
    logic [2:0] Log2N;
    logic       Stall;
    logic [3:0] Index;
    logic       IsB;
    logic [2:0] Stage;
    logic [2:0] Twiddle;
    logic       Valid;
    logic       Busy;
    logic       End;
    logic       CfgErr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int idx;
        int isb;
        int stg;
        int tw;
    } item_t;

    item_t q[$];

    fft_indexer_r2_cfg #(.BW_FFTP(4), .BW_STAGE(3)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Log2N(Log2N),
        .Stall(Stall), .Index(Index), .IsB(IsB), .Stage(Stage),
        .Twiddle(Twiddle), .Valid(Valid), .Busy(Busy), .End(End), .CfgErr(CfgErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: for each stage, butterfly b pairs A=(b div h)*2h + (b mod h) with A+h.
    task automatic build_model(input int l);
        int n, h, a, tw;
        q.delete();
        n = 1 << l;
        for (int s = 0; s < l; s++) begin
            h = 1 << (l - 1 - s);
            for (int b = 0; b < n / 2; b++) begin
                a  = (b / h) * 2 * h + (b % h);
                tw = (b % h) * (1 << (s + 4 - l));
                q.push_back('{idx: a,     isb: 0, stg: s, tw: tw});
                q.push_back('{idx: a + h, isb: 1, stg: s, tw: tw});
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, Valid, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_index"}, Index, 0);
        chk({tag, "_isb"}, IsB, 0);
        chk({tag, "_stage"}, Stage, 0);
        chk({tag, "_twiddle"}, Twiddle, 0);
    endtask

    // mode 0: no stall; 1: random stall plus stray Start/Log2N; 2: 3-cycle stall after 4 items
    task automatic run_seq(input int l, input int mode);
        int cyc, stalls, popped, stl;
        build_model(l);
        Start = 1'b1;
        Log2N = 3'(l);
        tick();
        Start = 1'b0;
        cyc = 1;
        stalls = 0;
        popped = 0;
        while (q.size() > 0 && cyc < 2000) begin
            chk("item_valid", Valid, 1);
            chk("item_end", End, 0);
            chk("item_index", Index, q[0].idx);
            chk("item_isb", IsB, q[0].isb);
            chk("item_stage", Stage, q[0].stg);
            chk("item_twiddle", Twiddle, q[0].tw);
            stl = 0;
            if (mode == 1) begin
                stl   = ($urandom % 4 == 0) ? 1 : 0;
                Start = 1'($urandom);
                Log2N = 3'($urandom);
            end else if (mode == 2) begin
                stl = (popped == 4 && stalls < 3) ? 1 : 0;
            end
            Stall = 1'(stl);
            tick();
            cyc++;
            if (stl != 0) stalls++;
            else begin
                void'(q.pop_front());
                popped++;
            end
        end
        Stall = 1'b0;
        Start = 1'b0;
        chk("seq_timeout_left", q.size(), 0);
        chk("seq_end_pulse", End, 1);
        chk("seq_end_cycle", cyc, l * (1 << l) + stalls + 1);
        chk_idle("seq_done");
    endtask

    initial begin
        Reset_n = 1'b0;
        Start   = 1'b0;
        Log2N   = '0;
        Stall   = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset_end", End, 0);
        chk("reset_cfgerr", CfgErr, 0);

        // Start on the first cycle after reset release, L=2, no stall
        Reset_n = 1'b1;
        run_seq(2, 0);
        tick();
        chk("l2_end_single", End, 0);

        run_seq(4, 0);
        tick();

        run_seq(2, 2);
        tick();

        // Rejected configurations
        Start = 1'b1;
        Log2N = 3'd0;
        tick();
        Start = 1'b0;
        chk("cfg0_err", CfgErr, 1);
        chk_idle("cfg0");
        tick();
        chk("cfg0_err_clear", CfgErr, 0);
        chk("cfg0_still_idle", Busy, 0);
        Start = 1'b1;
        Log2N = 3'd5;
        tick();
        Start = 1'b0;
        chk("cfg5_err", CfgErr, 1);
        chk_idle("cfg5");
        tick();
        chk("cfg5_err_clear", CfgErr, 0);

        // Reset in the middle of an L=3 run, at the fifth output
        build_model(3);
        Start = 1'b1;
        Log2N = 3'd3;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        chk("rst_mid_index_before", Index, q[4].idx);
        Reset_n = 1'b0;
        Start = 1'b1;
        Log2N = 3'd0;
        tick();
        Start = 1'b0;
        chk_idle("rst_mid");
        chk("rst_mid_end", End, 0);
        chk("rst_mid_cfgerr", CfgErr, 0);
        tick();
        chk("rst_mid_end2", End, 0);
        Reset_n = 1'b1;
        run_seq(3, 0);
        tick();

        // L=1, Start held on the End cycle is ignored, accepted one cycle later
        run_seq(1, 0);
        Start = 1'b1;
        Log2N = 3'd1;
        tick();
        chk("l1_start_on_end_ignored", Busy, 0);
        chk("l1_end_single", End, 0);
        run_seq(1, 0);
        tick();

        // Randomized sizes with random stalls and stray Start/Log2N while busy
        repeat (8) begin
            run_seq(int'($urandom_range(1, 4)), 1);
            tick();
            chk("rand_end_single", End, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
